cpu_handshake_arbiter: RTL and testbench

CPU-side controller for the four-phase send/ack link to the peripheral. Two internal requesters share the single `cpu_send`/`cpu_ack`/`cpu_dados` link. The block arbitrates between them round-robin, drives the full handshake (raise send, wait ack, drop send, wait ack low) and returns a per-requester completion or timeout pulse. `cpu_ack` comes from the peripheral clock domain and is synchronised internally.

---
 rtl/cpu_handshake_arbiter.sv | 163 ++++++++++++++++
 tb/tb_cpu_handshake_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_handshake_arbiter.sv
// cpu_handshake_arbiter
//
// CPU-side master for a four-phase send/ack link. Two local requesters share
// the link; ties are broken round-robin. The block drives the full handshake
// (raise send, wait ack high, drop send, wait ack low) and reports completion
// with a done pulse or an abort with an err pulse after a timeout.
//
// Ports:
//   cpu_clk            sole clock, rising edge
//   cpu_rst            asynchronous active-low reset
//   req0, req1         level requests, held until the matching done/err pulse
//   dados0, dados1     payload per requester, sampled at grant
//   done0, done1       one-cycle completion pulse per requester
//   err, err_id        one-cycle abort pulse and the aborted requester
//   busy               high whenever the controller is not idle
//   cpu_send           handshake request to the peripheral
//   cpu_ack            handshake acknowledge from the peripheral (async)
//   cpu_dados          payload to the peripheral, stable while cpu_send=1
module cpu_handshake_arbiter #(
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] dados0,
  input  logic [DATA_W-1:0] dados1,
  output logic              done0,
  output logic              done1,
  output logic              err,
  output logic              err_id,
  output logic              busy,
  output logic              cpu_send,
  input  logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_dados
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_RELEASE,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               gnt_id;
  logic               last_gnt;
  logic               ack_m;
  logic               ack_s;
  logic               win_id;

  // Two-flop synchroniser for the peripheral-domain acknowledge. Only ack_s
  // is ever looked at by the state machine.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours (ack_s gets old ack_m).
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= cpu_ack;
      ack_s <= ack_m;
    end
  end

  // A lone request wins outright; on a tie the requester that was not
  // served last goes next.
  assign win_id = (req0 && req1) ? ~last_gnt : req1;

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      gnt_id    <= 1'b0;
      last_gnt  <= 1'b1;
      cpu_send  <= 1'b0;
      cpu_dados <= '0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      err       <= 1'b0;
      err_id    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // A still-high ack belongs to a previous exchange; starting a new
          // one would be seen as instantly acknowledged.
          if ((req0 || req1) && !ack_s) begin
            gnt_id    <= win_id;
            cpu_dados <= win_id ? dados1 : dados0;
            cpu_send  <= 1'b1;
            busy      <= 1'b1;
            cnt       <= '0;
            state     <= S_SEND;
          end
        end

        S_SEND: begin
          if (ack_s) begin
            cpu_send <= 1'b0;
            cnt      <= '0;
            state    <= S_RELEASE;
          end else if (cnt == CNT_LAST) begin
            cpu_send <= 1'b0;
            err      <= 1'b1;
            err_id   <= gnt_id;
            last_gnt <= gnt_id;
            state    <= S_ERR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_RELEASE: begin
          if (!ack_s) begin
            done0    <= ~gnt_id;
            done1    <= gnt_id;
            last_gnt <= gnt_id;
            state    <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            err      <= 1'b1;
            err_id   <= gnt_id;
            last_gnt <= gnt_id;
            state    <= S_ERR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DONE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        S_ERR: begin
          err    <= 1'b0;
          err_id <= 1'b0;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          cpu_send <= 1'b0;
          done0    <= 1'b0;
          done1    <= 1'b0;
          err      <= 1'b0;
          err_id   <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_handshake_arbiter.sv
// Self-checking bench for cpu_handshake_arbiter (DATA_W=4, TIMEOUT=15).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, well away from the next active edge.
module tb_cpu_handshake_arbiter;

  logic       cpu_clk;
  logic       cpu_rst;
  logic       req0, req1;
  logic [3:0] dados0, dados1;
  logic       done0, done1, err, err_id, busy, cpu_send;
  logic       cpu_ack;
  logic [3:0] cpu_dados;

  // Peripheral: either a forced level or a model that acks one cycle after
  // send rises and releases one cycle after send falls.
  logic periph_en;
  logic ack_force;
  logic ack_model;

  int checks;
  int failures;

  cpu_handshake_arbiter #(.DATA_W(4), .TIMEOUT(15)) dut (
    .cpu_clk  (cpu_clk),
    .cpu_rst  (cpu_rst),
    .req0     (req0),
    .req1     (req1),
    .dados0   (dados0),
    .dados1   (dados1),
    .done0    (done0),
    .done1    (done1),
    .err      (err),
    .err_id   (err_id),
    .busy     (busy),
    .cpu_send (cpu_send),
    .cpu_ack  (cpu_ack),
    .cpu_dados(cpu_dados)
  );

  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  always @(posedge cpu_clk) ack_model <= cpu_send;
  assign cpu_ack = periph_en ? ack_model : ack_force;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       r0, r1;
    logic [3:0] d0, d1;
    logic       ack;
    logic       e_busy, e_send;
    logic [3:0] e_dados;
    logic       e_done0, e_done1, e_err, e_eid;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  function automatic logic [9:0] outs();
    return {busy, cpu_send, cpu_dados, done0, done1, err, err_id};
  endfunction

  // Waits for the next completion, checking the payload while send is high
  // and that the pulse belongs to the expected requester.
  task automatic wait_done(input logic exp_id, input logic [3:0] exp_data, input bit drop);
    logic [2:0]  got_pulse;
    logic [31:0] got_data;
    bit          send_seen;
    got_pulse = 3'b000;
    got_data  = 32'hDEAD;
    send_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (cpu_send) begin
        if (!send_seen || cpu_dados !== exp_data) got_data = {28'd0, cpu_dados};
        send_seen = 1'b1;
      end
      if (done0 || done1 || err) begin
        got_pulse = {err, done1, done0};
        if (drop) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
        break;
      end
    end
    check("txn_payload", got_data, {28'd0, exp_data});
    check("txn_pulse", {29'd0, got_pulse}, exp_id ? 32'd2 : 32'd1);
  endtask

  initial begin
    int          cnt_a, cnt_b, cnt_c;
    logic        eid;
    logic [2:0]  bseq;
    bit          bad;

    checks    = 0;
    failures  = 0;
    cpu_rst   = 1'b0;
    req0      = 1'b0;
    req1      = 1'b0;
    dados0    = 4'h0;
    dados1    = 4'h0;
    periph_en = 1'b0;
    ack_force = 1'b0;

    // Single transaction, one record per cycle: inputs applied, then the
    // outputs after the following edge are compared.
    vt[0] = '{1'b1, 1'b0, 4'hA, 4'hF, 1'b0, 1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 4'hA, 4'hF, 1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b0, 4'h2, 4'hF, 1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b0, 4'hA, 4'hF, 1'b1, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 1'b0, 4'hA, 4'hF, 1'b0, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b0, 4'hA, 4'hF, 1'b0, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6] = '{1'b1, 1'b0, 4'hA, 4'hF, 1'b0, 1'b1, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[7] = '{1'b0, 1'b0, 4'hA, 4'hF, 1'b0, 1'b0, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8] = '{1'b0, 1'b0, 4'h5, 4'hF, 1'b0, 1'b0, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    #12;
    check("reset_outputs", {22'd0, outs()}, 32'd0);
    step();
    step();
    cpu_rst = 1'b1;
    step();
    check("idle_after_reset", {22'd0, outs()}, 32'd0);

    // Single transaction from the table
    for (int i = 0; i < 9; i++) begin
      req0      = vt[i].r0;
      req1      = vt[i].r1;
      dados0    = vt[i].d0;
      dados1    = vt[i].d1;
      ack_force = vt[i].ack;
      step();
      check($sformatf("vec%0d", i), {22'd0, outs()},
            {22'd0, vt[i].e_busy, vt[i].e_send, vt[i].e_dados,
             vt[i].e_done0, vt[i].e_done1, vt[i].e_err, vt[i].e_eid});
    end

    // Data isolation: payload change during SEND is ignored
    periph_en = 1'b1;
    dados0    = 4'h1;
    req0      = 1'b1;
    for (int i = 0; i < 5 && !cpu_send; i++) step();
    dados0 = 4'h7;
    wait_done(1'b0, 4'h1, 1'b1);
    step();
    step();
    check("dados_hold", {28'd0, cpu_dados}, 32'h1);
    req0 = 1'b1;
    wait_done(1'b0, 4'h7, 1'b1);
    step();

    // Stuck-low ack: SEND times out after exactly 15 cycles
    periph_en = 1'b0;
    ack_force = 1'b0;
    dados1    = 4'h9;
    req1      = 1'b1;
    cnt_a = 0; cnt_b = 0; cnt_c = 0; eid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (cpu_send) cnt_a++;
      if (done1) cnt_c++;
      if (err) begin
        cnt_b++;
        eid  = err_id;
        req1 = 1'b0;
      end
    end
    check("send_timeout_len", cnt_a, 32'd15);
    check("send_timeout_err", {cnt_b[30:0], eid}, {31'd1, 1'b1});
    check("send_timeout_nodone", cnt_c, 32'd0);

    // Stuck-high ack after send drops: RELEASE times out after 15 cycles
    dados0 = 4'h4;
    req0   = 1'b1;
    step();
    ack_force = 1'b1;
    cnt_a = 0; cnt_b = 0; eid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy && !cpu_send && !err) cnt_a++;
      if (err) begin
        cnt_b++;
        eid       = err_id;
        req0      = 1'b0;
        ack_force = 1'b0;
      end
    end
    check("release_timeout_len", cnt_a, 32'd15);
    check("release_timeout_err", {cnt_b[30:0], eid}, {31'd1, 1'b0});

    // Stale high ack blocks the grant until it has been synchronised low
    ack_force = 1'b1;
    step(); step(); step();
    dados0 = 4'h6;
    req0   = 1'b1;
    bad    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (busy || cpu_send) bad = 1'b1;
    end
    check("stale_ack_blocks", {31'd0, bad}, 32'd0);
    ack_force = 1'b0;
    step(); bseq[2] = busy;
    step(); bseq[1] = busy;
    step(); bseq[0] = busy;
    check("grant_after_ack_low", {29'd0, bseq}, 32'd1);
    periph_en = 1'b1;
    wait_done(1'b0, 4'h6, 1'b1);
    step();

    // Reset during RELEASE: outputs clear at once, no done pulse
    dados0 = 4'h8;
    req0   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy && !cpu_send) break;
    end
    check("in_release", {30'd0, busy, cpu_send}, 32'd2);
    #2;
    cpu_rst = 1'b0;
    #1;
    check("async_reset_outputs", {22'd0, outs()}, 32'd0);
    req0 = 1'b0;
    bad  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done0 || done1 || err || busy) bad = 1'b1;
    end
    cpu_rst = 1'b1;
    step();
    if (done0 || done1 || err || busy) bad = 1'b1;
    check("no_pulse_after_reset", {31'd0, bad}, 32'd0);

    // Tie arbitration from reset: 0,1,0,1
    dados0 = 4'h3;
    dados1 = 4'h5;
    req0   = 1'b1;
    req1   = 1'b1;
    wait_done(1'b0, 4'h3, 1'b0);
    wait_done(1'b1, 4'h5, 1'b0);
    wait_done(1'b0, 4'h3, 1'b0);
    wait_done(1'b1, 4'h5, 1'b1);
    step();
    step();
    check("idle_at_end", {30'd0, busy, cpu_send}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
